// File: rtl/driver_monitor_pkg.sv
// -----------------------------------------------------------------------------
// driver_monitor_pkg
// Shared definitions for the driver behaviour monitor:
//   - drv_state_e   : SAFE / WARN / ALERT driver-state encoding
//   - EV_*          : bit positions inside the 4-bit event_code / flags vector
//   - DEF_*         : default thresholds and window sizing
//   - step_down()   : one-level de-escalation of the driver state
//   - abs9()        : magnitude of a 9-bit two's-complement value
// -----------------------------------------------------------------------------
package driver_monitor_pkg;

    typedef enum logic [1:0] {
        ST_SAFE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALERT = 2'd2
    } drv_state_e;

    localparam int EV_ACCEL = 0;
    localparam int EV_BRAKE = 1;
    localparam int EV_STEER = 2;
    localparam int EV_JERK  = 3;
    localparam int EV_W     = 4;

    localparam int DEF_ACCEL_TH      = 48;
    localparam int DEF_BRAKE_TH      = 150;
    localparam int DEF_STEER_TH      = 40;
    localparam int DEF_STEER_RATE_TH = 32;
    localparam int DEF_WINDOW        = 64;
    localparam int DEF_WARN_CNT      = 4;
    localparam int DEF_ALERT_CNT     = 8;
    localparam int DEF_CLEAR_WINDOWS = 2;

    // SAFE is the floor: stepping down from SAFE stays SAFE.
    function automatic drv_state_e step_down(input drv_state_e s);
        drv_state_e r;
        case (s)
            ST_ALERT: r = ST_WARN;
            default:  r = ST_SAFE;
        endcase
        return r;
    endfunction

    // Result always fits in 9 unsigned bits; -256 cannot occur for the
    // operands used here (sign-extended bytes and their differences).
    function automatic logic [8:0] abs9(input logic [8:0] v);
        return v[8] ? (~v + 9'd1) : v;
    endfunction

endpackage

// File: rtl/dm_event_classifier.sv
// -----------------------------------------------------------------------------
// dm_event_classifier
// Purely combinational threshold logic for one sensor sample.
// Ports:
//   accel      in  8  signed acceleration
//   steer      in  8  signed steering angle
//   brake      in  8  unsigned brake pressure
//   prev_steer in  8  signed steering angle of the previous sample
//   flags      out 4  {jerk, steer, brake, accel}; jerk is raw (the caller
//                     decides whether a previous sample exists)
// -----------------------------------------------------------------------------
module dm_event_classifier
    import driver_monitor_pkg::*;
#(
    parameter int ACCEL_TH      = DEF_ACCEL_TH,
    parameter int BRAKE_TH      = DEF_BRAKE_TH,
    parameter int STEER_TH      = DEF_STEER_TH,
    parameter int STEER_RATE_TH = DEF_STEER_RATE_TH
) (
    input  logic [7:0]      accel,
    input  logic [7:0]      steer,
    input  logic [7:0]      brake,
    input  logic [7:0]      prev_steer,
    output logic [EV_W-1:0] flags
);

    localparam logic signed [8:0] ACCEL_TH_S   = 9'(ACCEL_TH);
    localparam logic        [8:0] BRAKE_TH_U   = 9'(BRAKE_TH);
    localparam logic        [8:0] STEER_TH_U   = 9'(STEER_TH);
    localparam logic        [8:0] STEER_RATE_U = 9'(STEER_RATE_TH);

    logic signed [8:0] accel_s;
    logic        [8:0] steer_x;
    logic        [8:0] prev_x;
    logic        [8:0] steer_abs;
    logic        [8:0] steer_diff;
    logic        [8:0] diff_abs;

    // Everything is widened to 9 bits so that |-128| = 128 and the full
    // -255..255 steering delta are representable without wrap.
    always_comb begin
        accel_s    = $signed({accel[7], accel});
        steer_x    = {steer[7], steer};
        prev_x     = {prev_steer[7], prev_steer};
        steer_abs  = abs9(steer_x);
        steer_diff = steer_x - prev_x;
        diff_abs   = abs9(steer_diff);

        flags           = '0;
        flags[EV_ACCEL] = (accel_s > ACCEL_TH_S);
        flags[EV_BRAKE] = ({1'b0, brake} >= BRAKE_TH_U);
        flags[EV_STEER] = (steer_abs > STEER_TH_U);
        flags[EV_JERK]  = (diff_abs > STEER_RATE_U);
    end

endmodule

// File: rtl/driver_behavior_monitor.sv
// -----------------------------------------------------------------------------
// driver_behavior_monitor
// Samples accel/steer/brake, flags harsh-driving events, counts them over a
// window of WINDOW samples and maintains a SAFE/WARN/ALERT driver state.
// Optional feature macro: STEER_RATE_CHECK_EN adds the steering-jerk flag
// (event_code[3]); without it that bit is tied 0 and no prev_steer is kept.
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous reset, active-low
//   sample_en    in   1  accel/steer/brake valid this cycle
//   accel        in   8  signed acceleration
//   steer        in   8  signed steering angle
//   brake        in   8  unsigned brake pressure
//   clear        in   1  synchronous soft clear (same effect as reset)
//   harsh_event  out  1  pulse one cycle after a flagged sample
//   event_code   out  4  {jerk, steer, brake, accel}, 0 when harsh_event=0
//   window_done  out  1  pulse one cycle after the final sample of a window
//   win_count    out  8  event count of the last completed window
//   driver_state out  2  0=SAFE 1=WARN 2=ALERT
//   alert        out  1  driver_state == ALERT
// -----------------------------------------------------------------------------
module driver_behavior_monitor
    import driver_monitor_pkg::*;
#(
    parameter int ACCEL_TH      = DEF_ACCEL_TH,
    parameter int BRAKE_TH      = DEF_BRAKE_TH,
    parameter int STEER_TH      = DEF_STEER_TH,
    parameter int STEER_RATE_TH = DEF_STEER_RATE_TH,
    parameter int WINDOW        = DEF_WINDOW,
    parameter int WARN_CNT      = DEF_WARN_CNT,
    parameter int ALERT_CNT     = DEF_ALERT_CNT,
    parameter int CLEAR_WINDOWS = DEF_CLEAR_WINDOWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_en,
    input  logic [7:0] accel,
    input  logic [7:0] steer,
    input  logic [7:0] brake,
    input  logic       clear,
    output logic       harsh_event,
    output logic [3:0] event_code,
    output logic       window_done,
    output logic [7:0] win_count,
    output logic [1:0] driver_state,
    output logic       alert
);

    localparam logic [7:0] WIN_LAST  = 8'(WINDOW - 1);
    localparam logic [7:0] WARN_W    = 8'(WARN_CNT);
    localparam logic [7:0] ALERT_W   = 8'(ALERT_CNT);
    localparam logic [7:0] CLEAR_W   = 8'(CLEAR_WINDOWS);

    // Reset and soft clear have identical effect.
    logic flush;
    assign flush = !rst || clear;

    // ------------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------------
    logic [EV_W-1:0] raw_flags;
    logic [EV_W-1:0] ev_flags;
    logic [7:0]      cls_prev;
    logic            jerk_en;

`ifdef STEER_RATE_CHECK_EN
    logic [7:0] prev_steer_q;
    logic       prev_valid_q;

    // prev_valid_q suppresses the jerk flag on the first sample after
    // reset/clear, when there is no meaningful previous angle.
    always_ff @(posedge clk) begin
        if (flush) begin
            prev_steer_q <= '0;
            prev_valid_q <= 1'b0;
        end else if (sample_en) begin
            prev_steer_q <= steer;
            prev_valid_q <= 1'b1;
        end
    end

    assign cls_prev = prev_steer_q;
    assign jerk_en  = prev_valid_q;
`else
    assign cls_prev = '0;
    assign jerk_en  = 1'b0;
`endif

    dm_event_classifier #(
        .ACCEL_TH      (ACCEL_TH),
        .BRAKE_TH      (BRAKE_TH),
        .STEER_TH      (STEER_TH),
        .STEER_RATE_TH (STEER_RATE_TH)
    ) u_classifier (
        .accel      (accel),
        .steer      (steer),
        .brake      (brake),
        .prev_steer (cls_prev),
        .flags      (raw_flags)
    );

    always_comb begin
        ev_flags          = raw_flags;
        ev_flags[EV_JERK] = raw_flags[EV_JERK] & jerk_en;
    end

    // ------------------------------------------------------------------
    // Window / event counting
    // ------------------------------------------------------------------
    logic       harsh_q,     harsh_d;
    logic [3:0] code_q,      code_d;
    logic       done_q,      done_d;
    logic [7:0] win_count_q, win_count_d;
    logic [7:0] win_cnt_q,   win_cnt_d;
    logic [7:0] ev_cnt_q,    ev_cnt_d;

    logic       hit;
    logic       win_end;
    logic [7:0] ev_total;   // saturating count including the current sample

    always_comb begin
        hit      = sample_en && (ev_flags != '0);
        win_end  = sample_en && (win_cnt_q == WIN_LAST);
        ev_total = ev_cnt_q;
        if (hit && (ev_cnt_q != 8'hFF)) begin
            ev_total = ev_cnt_q + 8'd1;
        end

        harsh_d     = hit;
        code_d      = hit ? ev_flags : 4'd0;
        done_d      = 1'b0;
        win_count_d = win_count_q;
        win_cnt_d   = win_cnt_q;
        ev_cnt_d    = ev_cnt_q;

        if (win_end) begin
            done_d      = 1'b1;
            win_count_d = ev_total;
            win_cnt_d   = '0;
            ev_cnt_d    = '0;
        end else if (sample_en) begin
            win_cnt_d   = win_cnt_q + 8'd1;
            ev_cnt_d    = ev_total;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            harsh_q     <= 1'b0;
            code_q      <= '0;
            done_q      <= 1'b0;
            win_count_q <= '0;
            win_cnt_q   <= '0;
            ev_cnt_q    <= '0;
        end else begin
            harsh_q     <= harsh_d;
            code_q      <= code_d;
            done_q      <= done_d;
            win_count_q <= win_count_d;
            win_cnt_q   <= win_cnt_d;
            ev_cnt_q    <= ev_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Driver-state FSM, advanced only at window end
    // ------------------------------------------------------------------
    drv_state_e state_q, state_d;
    logic [7:0] clean_q, clean_d;

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q <= ST_SAFE;
            clean_q <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
        end
    end

    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        if (win_end) begin
            if (ev_total >= ALERT_W) begin
                state_d = ST_ALERT;
                clean_d = '0;
            end else if (ev_total >= WARN_W) begin
                // WARN-level windows escalate SAFE but never demote ALERT.
                if (state_q == ST_SAFE) begin
                    state_d = ST_WARN;
                end
                clean_d = '0;
            end else if ((clean_q + 8'd1) >= CLEAR_W) begin
                state_d = step_down(state_q);
                clean_d = '0;
            end else begin
                clean_d = clean_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign harsh_event  = harsh_q;
    assign event_code   = code_q;
    assign window_done  = done_q;
    assign win_count    = win_count_q;
    assign driver_state = state_q;
    assign alert        = (state_q == ST_ALERT);

endmodule

// File: tb/tb_driver_behavior_monitor.sv
// -----------------------------------------------------------------------------
// tb_driver_behavior_monitor
// Directed scenarios plus randomized traffic for driver_behavior_monitor.
// A spec-level model (integer sample/event counts and a 0..2 risk level)
// predicts every output; a compare process checks the DUT on each negedge,
// and directed steps pin a few outputs to hand-computed literals.
// Honours STEER_RATE_CHECK_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_driver_behavior_monitor;

    localparam int ACCEL_TH      = 48;
    localparam int BRAKE_TH      = 150;
    localparam int STEER_TH      = 40;
    localparam int STEER_RATE_TH = 32;
    localparam int WINDOW        = 64;
    localparam int WARN_CNT      = 4;
    localparam int ALERT_CNT     = 8;
    localparam int CLEAR_WINDOWS = 2;

`ifdef STEER_RATE_CHECK_EN
    localparam bit JERK_ON = 1'b1;
`else
    localparam bit JERK_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       sample_en;
    logic [7:0] accel;
    logic [7:0] steer;
    logic [7:0] brake;
    logic       clear;
    logic       harsh_event;
    logic [3:0] event_code;
    logic       window_done;
    logic [7:0] win_count;
    logic [1:0] driver_state;
    logic       alert;

    driver_behavior_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .accel        (accel),
        .steer        (steer),
        .brake        (brake),
        .clear        (clear),
        .harsh_event  (harsh_event),
        .event_code   (event_code),
        .window_done  (window_done),
        .win_count    (win_count),
        .driver_state (driver_state),
        .alert        (alert)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: integer counts, risk level 0..2
    // ------------------------------------------------------------------
    bit model_live = 1'b0;
    int m_samples  = 0;
    int m_events   = 0;
    int m_level    = 0;
    int m_clean    = 0;
    int m_prev     = 0;
    bit m_prev_ok  = 1'b0;
    bit exp_he     = 1'b0;
    int exp_code   = 0;
    bit exp_done   = 1'b0;
    int exp_wc     = 0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    always @(posedge clk) begin
        int a, s, b, code;
        model_live = 1'b1;
        if (!rst || clear) begin
            m_samples = 0; m_events = 0; m_level = 0; m_clean = 0;
            m_prev = 0; m_prev_ok = 1'b0;
            exp_he = 1'b0; exp_code = 0; exp_done = 1'b0; exp_wc = 0;
        end else begin
            exp_he   = 1'b0;
            exp_code = 0;
            exp_done = 1'b0;
            if (sample_en) begin
                a = int'($signed(accel));
                s = int'($signed(steer));
                b = int'(brake);
                code = 0;
                if (a > ACCEL_TH)          code += 1;
                if (b >= BRAKE_TH)         code += 2;
                if (iabs(s) > STEER_TH)    code += 4;
                if (JERK_ON && m_prev_ok && iabs(s - m_prev) > STEER_RATE_TH) code += 8;
                m_prev = s;
                m_prev_ok = 1'b1;
                exp_he   = (code != 0);
                exp_code = code;
                if (code != 0 && m_events < 255) m_events++;
                m_samples++;
                if (m_samples == WINDOW) begin
                    exp_done = 1'b1;
                    exp_wc   = m_events;
                    if (m_events >= ALERT_CNT) begin
                        m_level = 2; m_clean = 0;
                    end else if (m_events >= WARN_CNT) begin
                        if (m_level == 0) m_level = 1;
                        m_clean = 0;
                    end else begin
                        m_clean++;
                        if (m_clean >= CLEAR_WINDOWS) begin
                            if (m_level > 0) m_level--;
                            m_clean = 0;
                        end
                    end
                    m_samples = 0;
                    m_events  = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Cycle-by-cycle compare
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (model_live) begin
            chk("harsh_event", 32'(harsh_event), 32'(exp_he));
            if (exp_he) chk("event_code", 32'(event_code), 32'(exp_code));
            chk("window_done", 32'(window_done), 32'(exp_done));
            chk("win_count", 32'(win_count), 32'(exp_wc));
            chk("driver_state", 32'(driver_state), 32'(m_level));
            chk("alert", 32'(alert), 32'(m_level == 2));
            if (window_done)
                $display("window: count=%0d state=%0d t=%0t", win_count, driver_state, $time);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at the next negedge)
    // ------------------------------------------------------------------
    task automatic drive(input bit en, input int a, input int s, input int b, input bit clr);
        sample_en = en;
        accel     = 8'(a);
        steer     = 8'(s);
        brake     = 8'(b);
        clear     = clr;
        @(negedge clk);
    endtask

    // One full window of WINDOW samples, nev harsh-accel samples first,
    // sprinkled with idle cycles carrying harsh-looking data.
    task automatic run_window(input int nev);
        for (int i = 0; i < WINDOW; i++) begin
            if ($urandom_range(3) == 0) drive(1'b0, 100, 100, 200, 1'b0);
            drive(1'b1, (i < nev) ? 100 : 0, 0, 0, 1'b0);
        end
    endtask

    initial begin
        int pct;
        int r;
        int off;

        // 1. reset held for two cycles with live random samples
        rst = 1'b0; clear = 1'b0; sample_en = 1'b1;
        accel = 8'($urandom); steer = 8'($urandom); brake = 8'($urandom);
        @(negedge clk);
        drive(1'b1, int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(255)), 1'b0);
        chk("reset harsh_event", 32'(harsh_event), 0);
        chk("reset event_code", 32'(event_code), 0);
        chk("reset window_done", 32'(window_done), 0);
        chk("reset win_count", 32'(win_count), 0);
        chk("reset driver_state", 32'(driver_state), 0);
        chk("reset alert", 32'(alert), 0);
        rst = 1'b1;

        // 2. harsh acceleration, latency one cycle
        drive(1'b1, 60, 0, 0, 1'b0);
        chk("accel60 harsh_event", 32'(harsh_event), 1);
        chk("accel60 event_code", 32'(event_code), 1);
        chk("model pin accel60", 32'(exp_code), 1);

        // 3. steering magnitude and brake boundaries
        drive(1'b1, 0, -128, 0, 1'b0);
        chk("steer-128 event_code", 32'(event_code), JERK_ON ? 32'hC : 32'h4);
        drive(1'b1, 0, 0, 150, 1'b0);
        chk("brake150 event_code", 32'(event_code), JERK_ON ? 32'hA : 32'h2);
        drive(1'b1, 0, 0, 149, 1'b0);
        chk("brake149 harsh_event", 32'(harsh_event), 0);
        drive(1'b0, 100, 100, 200, 1'b0);
        chk("idle harsh_event", 32'(harsh_event), 0);

        // clear with a harsh sample in the same cycle: sample dropped
        drive(1'b1, 100, 0, 0, 1'b1);
        chk("clear drops sample", 32'(harsh_event), 0);

        // 4. window with exactly 8 harsh samples at random phase
        off = int'($urandom_range(7));
        for (int i = 0; i < WINDOW; i++) begin
            if ($urandom_range(3) == 0) drive(1'b0, 100, 0, 0, 1'b0);
            drive(1'b1, ((i % 8) == off) ? 100 : 0, 0, 0, 1'b0);
        end
        chk("w8 window_done", 32'(window_done), 1);
        chk("w8 win_count", 32'(win_count), 8);
        chk("w8 driver_state", 32'(driver_state), 2);
        chk("w8 alert", 32'(alert), 1);
        drive(1'b0, 0, 0, 0, 1'b0);
        chk("w8 done is a pulse", 32'(window_done), 0);

        // 5. de-escalation, interrupted once by a 5-event window
        run_window(0); chk("deesc clean1", 32'(driver_state), 2);
        run_window(5); chk("deesc 5ev", 32'(driver_state), 2);
        chk("deesc 5ev count", 32'(win_count), 5);
        run_window(0); chk("deesc clean1b", 32'(driver_state), 2);
        run_window(0); chk("deesc to WARN", 32'(driver_state), 1);
        run_window(3); chk("deesc 3ev", 32'(driver_state), 1);
        run_window(0); chk("deesc to SAFE", 32'(driver_state), 0);

        // 6. mid-window clear from ALERT
        run_window(9); chk("pre-clear alert", 32'(alert), 1);
        for (int i = 0; i < 10; i++) drive(1'b1, 0, 0, 0, 1'b0);
        drive(1'b1, 100, 0, 0, 1'b1);
        chk("clear harsh_event", 32'(harsh_event), 0);
        chk("clear driver_state", 32'(driver_state), 0);
        chk("clear win_count", 32'(win_count), 0);
        for (int i = 0; i < WINDOW - 1; i++) drive(1'b1, 0, 0, 0, 1'b0);
        chk("clear 63 no done", 32'(window_done), 0);
        drive(1'b1, 0, 0, 0, 1'b0);
        chk("clear 64 done", 32'(window_done), 1);

        // steering-rate: first sample after clear has no reference
        drive(1'b1, 0, 50, 0, 1'b1);
        drive(1'b1, 0, 0, 0, 1'b0);
        chk("jerk first sample", 32'(event_code[3]), 0);
        drive(1'b1, 0, 50, 0, 1'b0);
        chk("jerk second sample", 32'(event_code[3]), JERK_ON ? 1 : 0);
        chk("jerk event_code", 32'(event_code), JERK_ON ? 32'hC : 32'h4);

        // 7. randomized traffic with a per-window harsh density
        pct = 0;
        for (int n = 0; n < 3000; n++) begin
            int a, s, b;
            if ((n % WINDOW) == 0) begin
                r = int'($urandom_range(4));
                pct = (r == 0) ? 0 : (r == 1) ? 3 : (r == 2) ? 7 : (r == 3) ? 12 : 30;
            end
            r = int'($urandom_range(999));
            rst = (r < 3) ? 1'b0 : 1'b1;
            if (int'($urandom_range(99)) < pct) begin
                a = int'($urandom_range(255)) - 128;
                s = int'($urandom_range(255)) - 128;
                b = int'($urandom_range(255));
            end else if ($urandom_range(19) == 0) begin
                a = ($urandom_range(1) == 0) ? 48 : 49;
                b = ($urandom_range(1) == 0) ? 149 : 150;
                r = int'($urandom_range(4));
                s = (r == 0) ? 40 : (r == 1) ? 41 : (r == 2) ? -40 : (r == 3) ? -41 : -128;
            end else begin
                a = int'($urandom_range(80)) - 40;
                s = int'($urandom_range(30)) - 15;
                b = int'($urandom_range(140));
            end
            drive($urandom_range(3) != 0, a, s, b, ($urandom_range(999) < 3));
        end
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
